int_ctrl_nested: RTL and testbench
==================================

Name: int_ctrl_nested

Overview:
Parametrised successor of the three-line interrupt arbiter plus EPC unit for the pipelined CPU. It accepts NUM_IRQ edge-triggered lines through proper two-flop synchronisers, and adds per-line masking and fixed-priority arbitration. Higher-priority lines may preempt a running handler, nested up to DEPTH levels, with a return-address/priority stack. It sits beside the IF stage: Int/Iaddr redirect the PC, and EPC supplies the return PC on eret.

Parameters:
NUM_IRQ, 3, number of interrupt lines; index 0 is highest priority.
DEPTH, 2, maximum nesting levels (stack entries), >=1.
ADDR_W, 32, PC/address width.
VEC_BASE, 32'h00000100, vector address of line 0.
VEC_STRIDE, 32'h00000040, vector spacing; Iaddr = VEC_BASE + idx*VEC_STRIDE, truncated to ADDR_W.

Ports:
clk  in  1  system clock, rising edge.
CLR_n  in  1  reset, asynchronous assert, active-low; clears all state.
irq  in  NUM_IRQ  asynchronous interrupt request lines; rising edge requests service.
mask_we  in  1  write strobe for mask register.
mask_wdata  in  NUM_IRQ  new mask value; bit=1 blocks the line.
eret  in  1  return-from-interrupt, one-cycle pulse from decode.
epc_in  in  ADDR_W  return PC of the instruction being interrupted (computed by pipeline, J/B-corrected).
Int  out  1  one-cycle pulse: redirect fetch to Iaddr.
Iaddr  out  ADDR_W  vector of accepted line; held until next acceptance.
EPC  out  ADDR_W  return PC popped on eret; held until next pop.
cur_ir  out  clog2(NUM_IRQ+1)  line currently in service; NUM_IRQ = idle.
depth  out  clog2(DEPTH+1)  current nesting level.
pending  out  NUM_IRQ  latched-but-unserviced requests.
err  out  1  one-cycle pulse on eret with depth==0.

Behaviour:
- Reset (CLR_n low, async): sync flops, pending, mask, stack, Int, Iaddr, EPC, err = 0; cur_ir = NUM_IRQ; depth = 0.
- Input path: each irq bit goes through 2 sync flops plus 1 history flop; a rising edge on the synchronised value sets pending[i] on the next edge. Level-held irq sets pending once only.
- Eligible(i) = pending[i] & ~mask[i] & (i < cur_ir). Lower index wins. Masked lines keep pending set and fire when unmasked.
- Accept when: any eligible, depth < DEPTH, Int == 0, eret == 0. On accept edge:
  - push {cur_ir, epc_in} to stack[depth]; depth += 1; cur_ir <= idx;
  - clear pending[idx], but a new edge for the same line in that cycle re-sets it (set wins);
  - Iaddr <= vector(idx); Int <= 1 for exactly one cycle.
- Latency: irq high sampled at edge t gives pending at t+3 and Int high after edge t+4 (when idle and unmasked).
- At most one acceptance per cycle. No acceptance in the cycle Int is high, so back-to-back Ints are >=2 cycles apart.
- eret with depth > 0: pop stack[depth-1]; EPC <= stacked epc; cur_ir <= stacked cur_ir; depth -= 1. eret beats a same-cycle acceptance, which is deferred one cycle.
- eret with depth == 0: no state change; err pulses 1 cycle.
- depth == DEPTH: no acceptance, even for higher priority; requests stay pending.
- Equal or lower priority than cur_ir never preempts; it is served after eret lowers cur_ir.
- mask_we: mask <= mask_wdata at the edge. A same-cycle acceptance uses the old mask.
- Reset mid-service discards stack and pending; no Int after release until new edges arrive.

Test Plan:
- Reset, idle; pulse irq[1] 3 cycles -> one Int pulse 4 edges after first sampled high, Iaddr=32'h140, cur_ir=1, depth=1, pending=0.
- Nesting: irq[2] accepted with epc_in=32'h20; then irq[0] with epc_in=32'h304 -> Iaddr=32'h100, depth=2. eret -> EPC=32'h304, cur_ir=2. eret -> EPC=32'h20, cur_ir=3, depth=0.
- Priority block: in service of line 0, pulse irq[1] -> no Int, pending=3'b010. eret -> Int 2 cycles later, Iaddr=32'h140.
- Mask: mask=3'b001, pulse irq[0] -> no Int, pending[0]=1. Write mask=0 -> Int, Iaddr=32'h100.
- Depth full (DEPTH=2): lines 2 then 1 accepted; pulse irq[0] -> held pending until first eret, then accepted with depth back to 2.
- Underflow/reset: eret at depth 0 -> err pulse only. CLR_n low mid-nest -> depth=0, cur_ir=3, Int=0 immediately (async).

Source files
------------

// File: rtl/int_ctrl_nested.sv
// -----------------------------------------------------------------------------
// int_ctrl_nested
//   Nested, fixed-priority interrupt controller with EPC stack for the
//   pipelined CPU. Edge-triggered request lines are synchronised, latched as
//   pending, filtered by a mask and arbitrated (index 0 highest). A line may
//   preempt the handler currently running if it has strictly higher priority,
//   up to DEPTH nesting levels. Each acceptance pushes {cur_ir, epc_in}; eret
//   pops it back.
//
// Ports
//   clk        : system clock, rising edge
//   CLR_n      : asynchronous active-low reset
//   irq        : asynchronous request lines, rising edge requests service
//   mask_we    : mask register write strobe
//   mask_wdata : new mask (1 = line blocked)
//   eret       : return-from-interrupt pulse
//   epc_in     : return PC of the instruction being interrupted
//   Int        : one-cycle fetch redirect pulse
//   Iaddr      : vector address of the last accepted line
//   EPC        : return PC of the last popped stack entry
//   cur_ir     : line in service (NUM_IRQ = idle)
//   depth      : current nesting level
//   pending    : latched, not yet serviced requests
//   err        : one-cycle pulse on eret with an empty stack
// -----------------------------------------------------------------------------
module int_ctrl_nested #(
    parameter int unsigned       NUM_IRQ    = 3,
    parameter int unsigned       DEPTH      = 2,
    parameter int unsigned       ADDR_W     = 32,
    parameter logic [ADDR_W-1:0] VEC_BASE   = 'h100,
    parameter logic [ADDR_W-1:0] VEC_STRIDE = 'h40
) (
    input  logic                           clk,
    input  logic                           CLR_n,
    input  logic [NUM_IRQ-1:0]             irq,
    input  logic                           mask_we,
    input  logic [NUM_IRQ-1:0]             mask_wdata,
    input  logic                           eret,
    input  logic [ADDR_W-1:0]              epc_in,
    output logic                           Int,
    output logic [ADDR_W-1:0]              Iaddr,
    output logic [ADDR_W-1:0]              EPC,
    output logic [$clog2(NUM_IRQ+1)-1:0]   cur_ir,
    output logic [$clog2(DEPTH+1)-1:0]     depth,
    output logic [NUM_IRQ-1:0]             pending,
    output logic                           err
);

    localparam int unsigned IW = $clog2(NUM_IRQ + 1);
    localparam int unsigned DW = $clog2(DEPTH + 1);

    // Input synchroniser, history and registered edge flag.
    logic [NUM_IRQ-1:0] sync1_q, sync2_q, hist_q, rise_q;

    logic [NUM_IRQ-1:0] pending_q, pending_d;
    logic [NUM_IRQ-1:0] mask_q;

    logic [IW-1:0]      stk_ir_q [DEPTH];
    logic [ADDR_W-1:0]  stk_pc_q [DEPTH];

    logic               int_q;
    logic               err_q;
    logic [ADDR_W-1:0]  iaddr_q;
    logic [ADDR_W-1:0]  epc_q;
    logic [IW-1:0]      cur_ir_q;
    logic [DW-1:0]      depth_q;

    // Arbitration results
    logic               sel_found;
    logic [IW-1:0]      sel_idx;
    logic [NUM_IRQ-1:0] sel_oh;
    logic               do_accept;
    logic               do_pop;
    logic [IW-1:0]      pop_ir;
    logic [ADDR_W-1:0]  pop_pc;
    logic [ADDR_W-1:0]  vec_addr;

    // Lowest eligible index wins; only lines strictly above cur_ir preempt.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        sel_oh    = '0;
        for (int unsigned i = 0; i < NUM_IRQ; i++) begin
            if (!sel_found && pending_q[i] && !mask_q[i] && (IW'(i) < cur_ir_q)) begin
                sel_found = 1'b1;
                sel_idx   = IW'(i);
                sel_oh[i] = 1'b1;
            end
        end
    end

    // eret has priority; an acceptance is never taken while Int is high.
    assign do_accept = sel_found && (depth_q < DW'(DEPTH)) && !int_q && !eret;
    assign do_pop    = eret && (depth_q != '0);
    assign vec_addr  = VEC_BASE + (ADDR_W'(sel_idx) * VEC_STRIDE);

    // Top-of-stack read, selected by depth without a variable-width index.
    always_comb begin
        pop_ir = '0;
        pop_pc = '0;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            if (depth_q == DW'(k + 1)) begin
                pop_ir = stk_ir_q[k];
                pop_pc = stk_pc_q[k];
            end
        end
    end

    // Clear the accepted line, but a same-cycle new edge re-sets it.
    always_comb begin
        pending_d = pending_q;
        if (do_accept) begin
            pending_d = pending_d & ~sel_oh;
        end
        pending_d = pending_d | rise_q;
    end

    always_ff @(posedge clk or negedge CLR_n) begin
        if (!CLR_n) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            hist_q    <= '0;
            rise_q    <= '0;
            pending_q <= '0;
            mask_q    <= '0;
            for (int unsigned k = 0; k < DEPTH; k++) begin
                stk_ir_q[k] <= '0;
                stk_pc_q[k] <= '0;
            end
            int_q     <= 1'b0;
            err_q     <= 1'b0;
            iaddr_q   <= '0;
            epc_q     <= '0;
            cur_ir_q  <= IW'(NUM_IRQ);
            depth_q   <= '0;
        end else begin
            sync1_q   <= irq;
            sync2_q   <= sync1_q;
            hist_q    <= sync2_q;
            rise_q    <= sync2_q & ~hist_q;
            pending_q <= pending_d;
            if (mask_we) begin
                mask_q <= mask_wdata;
            end
            int_q <= do_accept;
            err_q <= eret && (depth_q == '0);
            if (do_pop) begin
                epc_q    <= pop_pc;
                cur_ir_q <= pop_ir;
                depth_q  <= depth_q - DW'(1);
            end else if (do_accept) begin
                for (int unsigned k = 0; k < DEPTH; k++) begin
                    if (depth_q == DW'(k)) begin
                        stk_ir_q[k] <= cur_ir_q;
                        stk_pc_q[k] <= epc_in;
                    end
                end
                depth_q  <= depth_q + DW'(1);
                cur_ir_q <= sel_idx;
                iaddr_q  <= vec_addr;
            end
        end
    end

    assign Int     = int_q;
    assign Iaddr   = iaddr_q;
    assign EPC     = epc_q;
    assign cur_ir  = cur_ir_q;
    assign depth   = depth_q;
    assign pending = pending_q;
    assign err     = err_q;

endmodule

// File: tb/tb_int_ctrl_nested.sv
// -----------------------------------------------------------------------------
// tb_int_ctrl_nested
//   Directed scenarios followed by a random phase. A transaction-level model
//   (sample history, queue-based return stack) predicts every output each
//   cycle; directed steps add explicit constant checks.
// -----------------------------------------------------------------------------
module tb_int_ctrl_nested;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        CLR_n;
    logic [2:0]  irq;
    logic        mask_we;
    logic [2:0]  mask_wdata;
    logic        eret;
    logic [31:0] epc_in;
    logic        Int;
    logic [31:0] Iaddr;
    logic [31:0] EPC;
    logic [1:0]  cur_ir;
    logic [1:0]  depth;
    logic [2:0]  pending;
    logic        err;

    int total = 0;
    int bad   = 0;

    int_ctrl_nested #(
        .NUM_IRQ   (3),
        .DEPTH     (DEPTH),
        .ADDR_W    (32),
        .VEC_BASE  (32'h0000_0100),
        .VEC_STRIDE(32'h0000_0040)
    ) dut (
        .clk       (clk),
        .CLR_n     (CLR_n),
        .irq       (irq),
        .mask_we   (mask_we),
        .mask_wdata(mask_wdata),
        .eret      (eret),
        .epc_in    (epc_in),
        .Int       (Int),
        .Iaddr     (Iaddr),
        .EPC       (EPC),
        .cur_ir    (cur_ir),
        .depth     (depth),
        .pending   (pending),
        .err       (err)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    typedef struct {
        int          ir;
        logic [31:0] pc;
    } ent_t;

    ent_t        m_stk[$];
    logic [2:0]  m_smp [0:4];   // irq as sampled at the last five edges, [0] newest
    logic [2:0]  m_pend;
    logic [2:0]  m_mask;
    int          m_cur;
    logic        m_int;
    logic        m_err;
    logic [31:0] m_iaddr;
    logic [31:0] m_epc;

    function automatic void model_reset();
        m_stk.delete();
        for (int k = 0; k < 5; k++) m_smp[k] = 3'b000;
        m_pend  = 3'b000;
        m_mask  = 3'b000;
        m_cur   = 3;
        m_int   = 1'b0;
        m_err   = 1'b0;
        m_iaddr = 32'h0;
        m_epc   = 32'h0;
    endfunction

    // One rising edge: a line whose sample went 0->1 three edges ago becomes pending now.
    function automatic void model_edge();
        logic [2:0] rise;
        int   acc;
        logic nint;
        logic nerr;
        ent_t e;
        for (int k = 4; k > 0; k--) m_smp[k] = m_smp[k-1];
        m_smp[0] = irq;
        rise = m_smp[3] & ~m_smp[4];
        acc  = -1;
        nint = 1'b0;
        nerr = 1'b0;
        if (eret) begin
            if (m_stk.size() > 0) begin
                e     = m_stk.pop_back();
                m_epc = e.pc;
                m_cur = e.ir;
            end else begin
                nerr = 1'b1;
            end
        end else if (!m_int && m_stk.size() < DEPTH) begin
            for (int i = 0; i < 3; i++)
                if (acc < 0 && m_pend[i] && !m_mask[i] && i < m_cur) acc = i;
        end
        if (acc >= 0) begin
            e.ir = m_cur;
            e.pc = epc_in;
            m_stk.push_back(e);
            m_cur        = acc;
            m_iaddr      = 32'h100 + 32'(acc) * 32'h40;
            nint         = 1'b1;
            m_pend[acc]  = 1'b0;
        end
        m_pend = m_pend | rise;
        if (mask_we) m_mask = mask_wdata;
        m_int = nint;
        m_err = nerr;
    endfunction

    // ---------------- checking ----------------
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic cmp_model();
        chk("Int",     32'(Int),     32'(m_int));
        chk("Iaddr",   Iaddr,        m_iaddr);
        chk("EPC",     EPC,          m_epc);
        chk("cur_ir",  32'(cur_ir),  32'(m_cur));
        chk("depth",   32'(depth),   32'(m_stk.size()));
        chk("pending", 32'(pending), 32'(m_pend));
        chk("err",     32'(err),     32'(m_err));
    endtask

    task automatic tick();
        @(posedge clk);
        if (!CLR_n) model_reset();
        else        model_edge();
        #1;
        cmp_model();
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic pulse_irq(input int line);
        irq[line] = 1'b1;
        tick();
        irq[line] = 1'b0;
    endtask

    task automatic wait_int(input string tag);
        for (int i = 0; i < 12; i++) begin
            tick();
            if (Int) break;
        end
        chk(tag, 32'(Int), 32'd1);
    endtask

    task automatic do_eret();
        eret = 1'b1;
        tick();
        eret = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        CLR_n = 1'b0; irq = '0; mask_we = 1'b0; mask_wdata = '0;
        eret = 1'b0; epc_in = 32'h0;
        model_reset();
        ticks(3);
        chk("rst_cur_ir", 32'(cur_ir), 32'd3);
        chk("rst_depth",  32'(depth),  32'd0);
        chk("rst_Int",    32'(Int),    32'd0);
        CLR_n = 1'b1;
        ticks(2);

        // Single request on line 1: Int after the fourth edge past first sample.
        epc_in = 32'h0000_0A00;
        irq[1] = 1'b1;
        ticks(3);
        irq[1] = 1'b0;
        tick();
        chk("lat_no_int_t3", 32'(Int), 32'd0);
        tick();
        chk("lat_int_t4", 32'(Int),    32'd1);
        chk("lat_iaddr",  Iaddr,       32'h140);
        chk("lat_cur",    32'(cur_ir), 32'd1);
        chk("lat_depth",  32'(depth),  32'd1);
        tick();
        chk("lat_int_one", 32'(Int),     32'd0);
        chk("lat_pend0",   32'(pending), 32'd0);
        ticks(4);
        chk("level_once", 32'(pending), 32'd0);
        do_eret();
        chk("lat_epc", EPC, 32'h0000_0A00);
        ticks(2);

        // Nesting 2 then 0.
        epc_in = 32'h20;
        pulse_irq(2);
        wait_int("nest_int2");
        epc_in = 32'h304;
        pulse_irq(0);
        wait_int("nest_int0");
        chk("nest_iaddr", Iaddr,       32'h100);
        chk("nest_depth", 32'(depth),  32'd2);
        tick();
        do_eret();
        chk("nest_epc1", EPC,          32'h304);
        chk("nest_cur1", 32'(cur_ir),  32'd2);
        tick();
        do_eret();
        chk("nest_epc2", EPC,          32'h20);
        chk("nest_cur2", 32'(cur_ir),  32'd3);
        chk("nest_dep2", 32'(depth),   32'd0);
        ticks(2);

        // Lower priority does not preempt line 0.
        epc_in = 32'h500;
        pulse_irq(0);
        wait_int("prio_int0");
        pulse_irq(1);
        ticks(8);
        chk("prio_pend", 32'(pending), 32'b010);
        chk("prio_noint", 32'(Int),    32'd0);
        do_eret();
        tick();
        chk("prio_int1",  32'(Int),    32'd1);
        chk("prio_iaddr", Iaddr,       32'h140);
        tick();
        do_eret();
        ticks(2);

        // Masked line stays pending, fires once unmasked.
        mask_we = 1'b1; mask_wdata = 3'b001;
        tick();
        mask_we = 1'b0;
        pulse_irq(0);
        ticks(8);
        chk("mask_pend",  32'(pending), 32'b001);
        chk("mask_noint", 32'(Int),     32'd0);
        mask_we = 1'b1; mask_wdata = 3'b000;
        tick();
        mask_we = 1'b0;
        chk("mask_old_used", 32'(Int), 32'd0);
        tick();
        chk("mask_int",   32'(Int),    32'd1);
        chk("mask_iaddr", Iaddr,       32'h100);
        tick();
        do_eret();
        ticks(2);

        // Depth full holds line 0 until the first eret.
        pulse_irq(2);
        wait_int("full_int2");
        pulse_irq(1);
        wait_int("full_int1");
        pulse_irq(0);
        ticks(8);
        chk("full_pend",  32'(pending), 32'b001);
        chk("full_depth", 32'(depth),   32'd2);
        do_eret();
        chk("full_dep1",  32'(depth),   32'd1);
        tick();
        chk("full_int0",  32'(Int),     32'd1);
        chk("full_iaddr", Iaddr,        32'h100);
        chk("full_dep2",  32'(depth),   32'd2);
        for (int i = 0; i < 3; i++) begin
            tick();
            do_eret();
        end
        ticks(2);

        // Underflow: eret at depth 0 only pulses err.
        chk("uf_dep0", 32'(depth), 32'd0);
        do_eret();
        chk("uf_err",  32'(err),   32'd1);
        tick();
        chk("uf_err_one", 32'(err), 32'd0);

        // Asynchronous reset mid-nest.
        pulse_irq(2);
        wait_int("ar_int2");
        pulse_irq(0);
        wait_int("ar_int0");
        #2;
        CLR_n = 1'b0;
        #1;
        model_reset();
        chk("ar_depth", 32'(depth),  32'd0);
        chk("ar_cur",   32'(cur_ir), 32'd3);
        chk("ar_int",   32'(Int),    32'd0);
        ticks(2);
        CLR_n = 1'b1;
        ticks(8);
        chk("ar_quiet", 32'(Int), 32'd0);

        // Random phase against the model.
        for (int n = 0; n < 400; n++) begin
            for (int b = 0; b < 3; b++)
                if ($urandom_range(0, 7) == 0) irq[b] = ~irq[b];
            eret       = ($urandom_range(0, 9) == 0);
            mask_we    = ($urandom_range(0, 15) == 0);
            mask_wdata = 3'($urandom_range(0, 7));
            epc_in     = $urandom;
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
